sprite_blitter: RTL and testbench

Parametrised sprite drawing engine between the game FSM and `vga_adapter`. It accepts one draw request at a time (sprite index, top-left position, mode, colour) and walks the sprite's pixels in raster order. Each pixel is read from an external synchronous sprite ROM bank and emitted as one `x`/`y`/`colour`/`plot` beat per clock. Over a fixed-function per-sprite ROM module it adds:
- multi-sprite selection;
- transparency;
- rectangle fill and shape-masked erase;
- screen-edge clipping;
- a ready/done handshake.

---
 rtl/sprite_blitter.sv | 159 +++++++++++++++
 tb/tb_sprite_blitter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sprite drawing engine feeding vga_adapter from a sprite ROM bank
//
// Walks one sprite in raster order per request and emits one pixel beat per clock.
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (accepted on req_valid && req_ready)
//   req_sprite/x/y        : sprite index and top-left screen position
//   req_mode              : 00 opaque, 01 transparent, 10 fill, 11 masked fill
//   req_colour            : colour used by the fill modes
//   rom_sprite/rom_addr   : ROM bank select and pixel address (row*SPRITE_W + col)
//   rom_data              : ROM output, one-cycle read latency
//   vga_x/y/colour/plot   : registered pixel beat towards vga_adapter
//   busy, done            : request in progress, one-cycle completion pulse
module sprite_blitter #(
   parameter int SPRITE_W  = 16,
   parameter int SPRITE_H  = 16,
   parameter int N_SPRITES = 4,
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int COLOUR_W  = 3,
   parameter logic [COLOUR_W-1:0] TRANSPARENT = '0,
   localparam int SID_W  = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
   localparam int ADDR_W = (SPRITE_W * SPRITE_H > 1) ? $clog2(SPRITE_W * SPRITE_H) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [SID_W-1:0]    req_sprite,
   input  logic [X_W-1:0]      req_x,
   input  logic [Y_W-1:0]      req_y,
   input  logic [1:0]          req_mode,
   input  logic [COLOUR_W-1:0] req_colour,
   output logic [SID_W-1:0]    rom_sprite,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [COLOUR_W-1:0] rom_data,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot,
   output logic                busy,
   output logic                done
);

   localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(SPRITE_W - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(SPRITE_W * SPRITE_H - 1);
   localparam logic [X_W:0]      SCREEN_W_L = (X_W + 1)'(SCREEN_W);
   localparam logic [Y_W:0]      SCREEN_H_L = (Y_W + 1)'(SCREEN_H);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state, state_nxt;

   logic [X_W-1:0]      x_l;
   logic [Y_W-1:0]      y_l;
   logic [1:0]          mode_l;
   logic [COLOUR_W-1:0] colour_l;
   logic [COL_W-1:0]    col, p_col;
   logic [ROW_W-1:0]    row, p_row;
   logic                p_valid;
   logic                accept;
   logic                addr_last;
   logic [X_W:0]        px;
   logic [Y_W:0]        py;
   logic                plot_c;
   logic [COLOUR_W-1:0] colour_c;

   assign accept    = req_valid && req_ready;
   assign addr_last = (rom_addr == ADDR_LAST);

   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic; DRAIN waits until the pixel stage has emptied
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = RUN;
         RUN:     if (addr_last) state_nxt = DRAIN;
         DRAIN:   if (!p_valid)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      req_ready = (state == IDLE) && !reset;
      busy      = (state != IDLE);
   end

   // One bit wider than the screen coordinates so sprites running off the
   // right/bottom edge clip instead of wrapping back onto the screen.
   assign px = {1'b0, x_l} + (X_W + 1)'(p_col);
   assign py = {1'b0, y_l} + (Y_W + 1)'(p_row);

   // mode bit 0 enables transparency, mode bit 1 selects the latched colour
   always_comb begin
      plot_c   = p_valid && (px < SCREEN_W_L) && (py < SCREEN_H_L) &&
                 (!mode_l[0] || (rom_data != TRANSPARENT));
      colour_c = mode_l[1] ? colour_l : rom_data;
   end

   // address stage, pixel stage (aligned with rom_data) and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         rom_sprite <= '0;
         rom_addr   <= '0;
         x_l        <= '0;
         y_l        <= '0;
         mode_l     <= '0;
         colour_l   <= '0;
         col        <= '0;
         row        <= '0;
         p_col      <= '0;
         p_row      <= '0;
         p_valid    <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         done       <= 1'b0;
      end else begin
         if (accept) begin
            rom_sprite <= req_sprite;
            x_l        <= req_x;
            y_l        <= req_y;
            mode_l     <= req_mode;
            colour_l   <= req_colour;
            col        <= '0;
            row        <= '0;
            rom_addr   <= '0;
         end else if (state == RUN && !addr_last) begin
            rom_addr <= rom_addr + ADDR_W'(1);
            if (col == COL_LAST) begin
               col <= '0;
               row <= row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end
         p_valid    <= (state == RUN);
         p_col      <= col;
         p_row      <= row;
         vga_plot   <= plot_c;
         vga_x      <= px[X_W-1:0];
         vga_y      <= py[Y_W-1:0];
         vga_colour <= colour_c;
         done       <= (state == DRAIN) && !p_valid;
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - self-checking bench for sprite_blitter
module tb_sprite_blitter;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_sprite;
   logic [7:0] req_x;
   logic [6:0] req_y;
   logic [1:0] req_mode;
   logic [2:0] req_colour;
   logic [1:0] rom_sprite;
   logic [7:0] rom_addr;
   logic [2:0] rom_data;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       done;

   sprite_blitter dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_sprite(req_sprite),
      .req_x(req_x), .req_y(req_y), .req_mode(req_mode), .req_colour(req_colour),
      .rom_sprite(rom_sprite), .rom_addr(rom_addr), .rom_data(rom_data),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   logic [2:0] rom [0:3][0:255];
   always @(posedge clock) rom_data <= rom[rom_sprite][rom_addr];

   typedef struct {
      int sprite; int x; int y; int mode; int colour;
      int e_plots; int e_fx; int e_fy; int e_lx; int e_ly;
      int e_minx; int e_maxx; int e_done;
   } vec_t;

   vec_t vecs [7];

   int n_vec = 0;
   int n_bad = 0;
   int s_plots, s_fx, s_fy, s_lx, s_ly, s_minx, s_maxx, s_done, s_cerr, s_kerr;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic start_req(input int s, input int x, input int y, input int m, input int c);
      int ok;
      @(negedge clock);
      req_sprite = 2'(s); req_x = 8'(x); req_y = 7'(y); req_mode = 2'(m); req_colour = 3'(c);
      req_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         if (req_ready) begin ok = 1; break; end
         @(negedge clock);
      end
      chk("req_ready_idle", ok, 1);
      @(posedge clock);
      #1;
   endtask

   // Samples every cycle after the acceptance edge against a pixel model.
   task automatic collect(input int s, input int x0, input int y0, input int mode,
                          input int colour, input int abort_at);
      s_plots = 0; s_fx = -1; s_fy = -1; s_lx = -1; s_ly = -1;
      s_minx = 999; s_maxx = -1; s_done = -1; s_cerr = 0; s_kerr = 0;
      for (int n = 0; n <= 300; n++) begin
         int k, px, py, v, ec, ep;
         @(negedge clock);
         ep = 0; ec = 0; px = 0; py = 0;
         if (n >= 2 && n <= 257) begin
            k  = n - 2;
            px = x0 + k % 16;
            py = y0 + k / 16;
            v  = int'(rom[s][k]);
            ep = (px < 160 && py < 120 && ((mode & 1) == 0 || v != 0)) ? 1 : 0;
            ec = (mode & 2) ? colour : v;
         end
         if (int'(vga_plot) != ep) s_cerr++;
         else if (ep == 1 && (int'(vga_x) != px || int'(vga_y) != py || int'(vga_colour) != ec))
            s_cerr++;
         if (vga_plot) begin
            s_plots++;
            if (s_fx < 0) begin s_fx = int'(vga_x); s_fy = int'(vga_y); end
            s_lx = int'(vga_x); s_ly = int'(vga_y);
            if (int'(vga_x) < s_minx) s_minx = int'(vga_x);
            if (int'(vga_x) > s_maxx) s_maxx = int'(vga_x);
         end
         if (done) begin
            if (busy !== 1'b0 || req_ready !== 1'b1 || vga_plot !== 1'b0) s_kerr++;
            s_done = n;
            return;
         end else if (busy !== 1'b1 || req_ready !== 1'b0) begin
            s_kerr++;
         end
         if (abort_at > 0 && n == abort_at) return;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      start_req(v.sprite, v.x, v.y, v.mode, v.colour);
      req_valid = 1'b0;
      collect(v.sprite, v.x, v.y, v.mode, v.colour, 0);
      chk({tag, "_plots"}, s_plots, v.e_plots);
      chk({tag, "_first_x"}, s_fx, v.e_fx);
      chk({tag, "_first_y"}, s_fy, v.e_fy);
      chk({tag, "_last_x"}, s_lx, v.e_lx);
      chk({tag, "_last_y"}, s_ly, v.e_ly);
      chk({tag, "_min_x"}, s_minx, v.e_minx);
      chk({tag, "_max_x"}, s_maxx, v.e_maxx);
      chk({tag, "_done_cycle"}, s_done, v.e_done);
      chk({tag, "_pixel_errs"}, s_cerr, 0);
      chk({tag, "_ctrl_errs"}, s_kerr, 0);
      @(negedge clock);
      chk({tag, "_done_width"}, int'(done), 0);
   endtask

   initial begin
      int dn, pl;
      for (int a = 0; a < 256; a++) begin
         rom[0][a] = 3'((a * 3 + 1) % 8);
         rom[1][a] = 3'(a % 8);
         rom[2][a] = (a % 16 < 8) ? 3'd0 : 3'(((a % 16) + (a / 16)) % 7 + 1);
         rom[3][a] = 3'(a % 7 + 1);
      end
      //           spr  x    y   md col plots fx   fy   lx   ly  minx maxx done
      vecs[0] = '{1,   10,  20,  0, 0,  256, 10,  20,  25,  35,  10,  25, 258};
      vecs[1] = '{2,   10,  30,  1, 0,  128, 18,  30,  25,  45,  18,  25, 258};
      vecs[2] = '{1,    0,   0,  2, 5,  256,  0,   0,  15,  15,   0,  15, 258};
      vecs[3] = '{1,  150, 110,  0, 0,  100, 150, 110, 159, 119, 150, 159, 258};
      vecs[4] = '{2,   10,  30,  3, 0,  128, 18,  30,  25,  45,  18,  25, 258};
      vecs[5] = '{1,  100,   0,  1, 0,  224, 101,  0, 115,  15, 101, 115, 258};
      vecs[6] = '{3,  255, 127,  0, 0,    0, -1,  -1,  -1,  -1, 999,  -1, 258};

      reset = 1'b1; req_valid = 1'b0;
      req_sprite = '0; req_x = '0; req_y = '0; req_mode = '0; req_colour = '0;
      repeat (3) @(negedge clock);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_vga_plot", int'(vga_plot), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_vga_xyc", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
      chk("rst_rom_addr", int'(rom_addr) + int'(rom_sprite), 0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle_req_ready", int'(req_ready), 1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // req_valid held high; fields changed right after acceptance
      start_req(1, 10, 20, 0, 0);
      req_sprite = 2'd3; req_x = 8'd40; req_y = 7'd50; req_mode = 2'd2; req_colour = 3'd6;
      collect(1, 10, 20, 0, 0, 0);
      chk("hs_a_plots", s_plots, 256);
      chk("hs_a_pixel_errs", s_cerr, 0);
      chk("hs_a_ctrl_errs", s_kerr, 0);
      chk("hs_a_done_cycle", s_done, 258);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      collect(3, 40, 50, 2, 6, 0);
      chk("hs_b_plots", s_plots, 256);
      chk("hs_b_first_x", s_fx, 40);
      chk("hs_b_first_y", s_fy, 50);
      chk("hs_b_pixel_errs", s_cerr, 0);
      chk("hs_b_ctrl_errs", s_kerr, 0);
      chk("hs_b_done_cycle", s_done, 258);
      @(negedge clock);

      // reset while pixel 50 is on the output
      start_req(1, 10, 20, 0, 0);
      req_valid = 1'b0;
      collect(1, 10, 20, 0, 0, 52);
      chk("rst_mid_pre_plots", s_plots, 51);
      chk("rst_mid_pre_errs", s_cerr + s_kerr, 0);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_mid_plot", int'(vga_plot), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_done", int'(done), 0);
      chk("rst_mid_ready", int'(req_ready), 0);
      reset = 1'b0;
      dn = 0; pl = 0;
      for (int i = 0; i < 260; i++) begin
         @(negedge clock);
         if (done) dn++;
         if (vga_plot) pl++;
      end
      chk("rst_mid_no_done", dn, 0);
      chk("rst_mid_no_plot", pl, 0);
      run_vec(vecs[0], "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
